// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and D-cache.
// One transaction at a time: IDLE -> GRANT_x (until mem_ready) -> DONE -> IDLE.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IC = 2'd1,
        GRANT_DC = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t state;
    logic   last_grant;   // 0 = IC won last, 1 = DC won last

    logic ic_req;
    logic dc_req;
    logic pick_dc;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        ic_req  = ic_read;
        dc_req  = dc_read | dc_write;
        pick_dc = dc_req & (~ic_req | ~last_grant);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ic_rdata   <= '0;
            dc_rdata   <= '0;
            ic_ready   <= 1'b0;
            dc_ready   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ic_req || dc_req) begin
                        busy <= 1'b1;
                        if (pick_dc) begin
                            state      <= GRANT_DC;
                            last_grant <= 1'b1;
                            // A simultaneous read+write from DC is a write-back.
                            mem_read   <= ~dc_write;
                            mem_write  <= dc_write;
                            mem_addr   <= dc_addr;
                            mem_wdata  <= dc_wdata;
                        end else begin
                            state      <= GRANT_IC;
                            last_grant <= 1'b0;
                            mem_read   <= 1'b1;
                            mem_write  <= 1'b0;
                            mem_addr   <= ic_addr;
                            mem_wdata  <= '0;
                        end
                    end
                end
                GRANT_IC: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        ic_rdata  <= mem_rdata;
                        ic_ready  <= 1'b1;
                        state     <= DONE;
                    end
                end
                GRANT_DC: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (mem_read) begin
                            dc_rdata <= mem_rdata;
                        end
                        dc_ready  <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Requests are deliberately not sampled here.
                    ic_ready <= 1'b0;
                    dc_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed test-plan scenarios followed by
// randomized traffic, all checked each cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_read;
    logic [AW-1:0] ic_addr;
    logic [DW-1:0] ic_rdata;
    logic          ic_ready;
    logic          dc_read;
    logic          dc_write;
    logic [AW-1:0] dc_addr;
    logic [DW-1:0] dc_wdata;
    logic [DW-1:0] dc_rdata;
    logic          dc_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .ic_read(ic_read), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
        .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ready(dc_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the port, what op, and what each cache sees.
    typedef enum int {M_FREE, M_OWNED, M_FINISH} phase_t;
    phase_t        m_phase;
    int            m_owner;          // 0 = IC, 1 = DC
    int            m_last;
    bit            m_is_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata [2];
    bit            m_ready [2];
    bit            m_active;

    task automatic model_step();
        bit want [2];
        int win;
        if (rst) begin
            m_phase  = M_FREE;
            m_last   = 1;
            m_active = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
            m_rdata[0] = '0;  m_rdata[1] = '0;
            m_ready[0] = 1'b0; m_ready[1] = 1'b0;
            return;
        end
        case (m_phase)
            M_FREE: begin
                want[0] = ic_read;
                want[1] = dc_read | dc_write;
                win = -1;
                if (want[0] && want[1]) win = 1 - m_last;
                else if (want[0])        win = 0;
                else if (want[1])        win = 1;
                if (win >= 0) begin
                    m_owner    = win;
                    m_last     = win;
                    m_is_write = (win == 1) && dc_write;
                    m_addr     = (win == 1) ? dc_addr : ic_addr;
                    m_wdata    = dc_wdata;
                    m_active   = 1'b1;
                    m_phase    = M_OWNED;
                end
            end
            M_OWNED: begin
                if (mem_ready) begin
                    m_active = 1'b0;
                    if (!m_is_write) m_rdata[m_owner] = mem_rdata;
                    m_ready[m_owner] = 1'b1;
                    m_phase = M_FINISH;
                end
            end
            default: begin
                m_ready[0] = 1'b0;
                m_ready[1] = 1'b0;
                m_phase    = M_FREE;
            end
        endcase
    endtask

    // Per-cycle compare against the model, just after each rising edge.
    always begin
        @(posedge clk);
        model_step();
        #1;
        chk("busy",      DW'(busy),      DW'(m_phase != M_FREE));
        chk("ic_ready",  DW'(ic_ready),  DW'(m_ready[0]));
        chk("dc_ready",  DW'(dc_ready),  DW'(m_ready[1]));
        chk("ic_rdata",  ic_rdata,       m_rdata[0]);
        chk("dc_rdata",  dc_rdata,       m_rdata[1]);
        chk("mem_read",  DW'(mem_read),  DW'(m_active && !m_is_write));
        chk("mem_write", DW'(mem_write), DW'(m_active && m_is_write));
        if (m_active) chk("mem_addr", DW'(mem_addr), DW'(m_addr));
        if (m_active && m_is_write) chk("mem_wdata", mem_wdata, m_wdata);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [DW-1:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [DW-1:0] D2 = 128'h55AA55AA_11112222_33334444_66667777;
    localparam logic [DW-1:0] W1 = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    localparam logic [AW-1:0] A_IC = 28'h0000010;
    localparam logic [AW-1:0] A_DC = 28'h0ABCDEF;

    initial begin
        logic [AW-1:0] order [4];
        int n;
        rst = 1'b1; ic_read = 1'b0; ic_addr = '0; dc_read = 1'b0; dc_write = 1'b0;
        dc_addr = '0; dc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", DW'(busy), '0);
        chk("rst_mem_read", DW'(mem_read), '0);
        chk("rst_ic_rdata", ic_rdata, '0);

        // Single IC read with 4-cycle memory latency.
        ic_read = 1'b1; ic_addr = A_IC;
        tick();
        chk("t1_mem_read", DW'(mem_read), DW'(1'b1));
        chk("t1_mem_addr", DW'(mem_addr), DW'(A_IC));
        tick(); tick(); tick();
        mem_ready = 1'b1; mem_rdata = D1;
        tick();
        mem_ready = 1'b0; ic_read = 1'b0;
        chk("t1_ic_ready", DW'(ic_ready), DW'(1'b1));
        chk("t1_ic_rdata", ic_rdata, D1);
        chk("t1_busy_done", DW'(busy), DW'(1'b1));
        tick();
        chk("t1_ic_ready_off", DW'(ic_ready), '0);
        chk("t1_busy_off", DW'(busy), '0);

        // Tie right after reset: IC first, then DC.
        rst = 1'b1; tick(); rst = 1'b0;
        ic_read = 1'b1; ic_addr = A_IC; dc_read = 1'b1; dc_addr = A_DC;
        tick();
        chk("t2_first_ic", DW'(mem_addr), DW'(A_IC));
        mem_ready = 1'b1; mem_rdata = D1;
        tick();
        mem_ready = 1'b0; ic_read = 1'b0;
        chk("t2_ic_ready", DW'({ic_ready, dc_ready}), DW'(2'b10));
        tick();
        chk("t2_idle_gap", DW'({ic_ready, dc_ready, busy}), '0);
        tick();
        chk("t2_second_dc", DW'(mem_addr), DW'(A_DC));
        mem_ready = 1'b1; mem_rdata = D2;
        tick();
        mem_ready = 1'b0; dc_read = 1'b0;
        chk("t2_dc_ready", DW'({ic_ready, dc_ready}), DW'(2'b01));
        chk("t2_dc_rdata", dc_rdata, D2);
        tick();

        // DC write with inputs changing mid-grant.
        dc_write = 1'b1; dc_addr = A_DC; dc_wdata = W1;
        tick();
        chk("t3_mem_write", DW'({mem_read, mem_write}), DW'(2'b01));
        dc_addr = 28'h1111111; dc_wdata = '1;
        tick(); tick();
        chk("t3_addr_hold", DW'(mem_addr), DW'(A_DC));
        chk("t3_wdata_hold", mem_wdata, W1);
        mem_ready = 1'b1; mem_rdata = D1;
        tick();
        mem_ready = 1'b0; dc_write = 1'b0;
        chk("t3_dc_ready", DW'(dc_ready), DW'(1'b1));
        chk("t3_dc_rdata_kept", dc_rdata, D2);
        tick();

        // Fairness: both held, four grants alternate starting with IC.
        ic_read = 1'b1; ic_addr = A_IC; dc_read = 1'b1; dc_addr = A_DC;
        order[0] = A_IC; order[1] = A_DC; order[2] = A_IC; order[3] = A_DC;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (!(mem_read || mem_write) && n < 20) begin tick(); n++; end
            chk("t4_grant_seen", DW'(mem_read), DW'(1'b1));
            chk("t4_order", DW'(mem_addr), DW'(order[t]));
            tick();
            mem_ready = 1'b1; mem_rdata = rand_line();
            tick();
            mem_ready = 1'b0;
        end
        ic_read = 1'b0;
        tick(); tick();

        // Reset while DC is granted, with mem_ready in the same cycle.
        n = 0;
        while (!mem_read && n < 20) begin tick(); n++; end
        chk("t5_dc_granted", DW'(mem_addr), DW'(A_DC));
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = D1;
        tick();
        chk("t5_all_zero", DW'({mem_read, mem_write, dc_ready, ic_ready, busy}), '0);
        chk("t5_dc_rdata", dc_rdata, '0);
        rst = 1'b0; mem_ready = 1'b0; ic_read = 1'b1;
        tick();
        chk("t5_tie_ic", DW'(mem_addr), DW'(A_IC));
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; ic_read = 1'b0; dc_read = 1'b0;
        tick(); tick();

        // Spurious mem_ready in IDLE, then combined read+write.
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("t6_spurious", DW'({ic_ready, dc_ready, busy}), '0);
        dc_read = 1'b1; dc_write = 1'b1; dc_wdata = W1;
        tick();
        chk("t6_write_only", DW'({mem_read, mem_write}), DW'(2'b01));
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; dc_read = 1'b0; dc_write = 1'b0;
        tick();

        // Randomized traffic, checked by the per-cycle compare.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (ic_read) ic_read = ($urandom_range(0, 7) != 0);
            else         ic_read = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 3) == 0) ic_addr = AW'($urandom);
            if (dc_read || dc_write) begin
                if ($urandom_range(0, 7) == 0) begin dc_read = 1'b0; dc_write = 1'b0; end
            end else begin
                dc_read  = ($urandom_range(0, 2) == 0);
                dc_write = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 3) == 0) dc_addr = AW'($urandom);
            dc_wdata  = rand_line();
            mem_rdata = rand_line();
            mem_ready = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 1'b0; ic_read = 1'b0; dc_read = 1'b0; dc_write = 1'b0; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
